// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO pop scheduler.
//   sched_state_e : scheduler FSM states
//   FIFO_EMPTY    : pop-flag value the FIFO reports when it has no data
//   lat_cnt_t     : read-latency counter type (covers RD_LAT of 1..7)
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StWait,
        StDeliver
    } sched_state_e;

    localparam logic [3:0] FIFO_EMPTY = 4'h0;

    localparam int unsigned LatCntW = 3;
    typedef logic [LatCntW-1:0] lat_cnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req_i     : request vector, bit n = requester n
//   last_i    : requester granted most recently
//   en_i      : arbitration allowed this cycle
//   gnt_vld_o : a requester is granted
//   gnt_id_o  : granted requester (valid with gnt_vld_o)
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_vld_o = en_i & (|req_i);
        // On a tie the requester that did not win last time goes first.
        if (&req_i) begin
            gnt_id_o = ~last_i;
        end else begin
            gnt_id_o = req_i[1];
        end
    end

endmodule

// File: rtl/fifo_pop_scheduler.sv
// Shares the pop port of one fabric FIFO between a Wishbone read path (requester 0)
// and a streaming consumer (requester 1). Each transaction is a single pop pulse,
// RD_LAT wait cycles, then a one-cycle valid strobe to the granted requester.
//   WBs_CLK_i, WBs_RSTn_i : clock, asynchronous active-low reset
//   req0_i, req1_i        : level requests
//   flush_i               : abort of the in-flight transaction
//   fifo_pop_flag_i       : FIFO pop flag, FIFO_EMPTY when empty
//   fifo_dout_i           : FIFO read data
//   fifo_pop_o            : single-cycle pop pulse
//   vld0_o, vld1_o        : one-cycle data valid per requester
//   dat_o                 : last captured word
//   gnt_id_o              : last granted requester
//   busy_o                : transaction in flight
//   dropped_o             : sticky, a popped word was discarded by flush
//   pop_cnt_o             : wrapping count of pops issued
module fifo_pop_scheduler #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned FLAGWIDTH = 4
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RSTn_i,
    input  logic                 req0_i,
    input  logic                 req1_i,
    input  logic                 flush_i,
    input  logic [FLAGWIDTH-1:0] fifo_pop_flag_i,
    input  logic [DATAWIDTH-1:0] fifo_dout_i,
    output logic                 fifo_pop_o,
    output logic                 vld0_o,
    output logic                 vld1_o,
    output logic [DATAWIDTH-1:0] dat_o,
    output logic                 gnt_id_o,
    output logic                 busy_o,
    output logic                 dropped_o,
    output logic [15:0]          pop_cnt_o
);

    import fifo_sched_pkg::*;

    sched_state_e         state_q, state_d;
    lat_cnt_t             lat_cnt_q, lat_cnt_d;
    logic                 last_q, last_d;
    logic                 gnt_q, gnt_d;
    logic                 pop_q, pop_d;
    logic                 vld0_q, vld0_d;
    logic                 vld1_q, vld1_d;
    logic [DATAWIDTH-1:0] dat_q, dat_d;
    logic                 busy_q, busy_d;
    logic                 drop_q, drop_d;
    logic [15:0]          pop_cnt_q, pop_cnt_d;

    logic fifo_has_data;
    logic arb_en;
    logic gnt_vld;
    logic gnt_id;
    logic start;

    assign fifo_has_data = (fifo_pop_flag_i != FLAGWIDTH'(FIFO_EMPTY));
    // Arbitrate only when no transaction is pending; flush vetoes any grant.
    assign arb_en = fifo_has_data && !flush_i && (state_q == StIdle || state_q == StDeliver);

    rr_arb2 u_rr_arb2 (
        .req_i     ({req1_i, req0_i}),
        .last_i    (last_q),
        .en_i      (arb_en),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        pop_d     = 1'b0;
        vld0_d    = 1'b0;
        vld1_d    = 1'b0;
        dat_d     = dat_q;
        drop_d    = drop_q;
        pop_cnt_d = pop_cnt_q;
        start     = 1'b0;

        unique case (state_q)
            StIdle: begin
                start = gnt_vld;
            end
            StPop: begin
                if (flush_i) begin
                    state_d = StIdle;
                    drop_d  = 1'b1;
                end else begin
                    state_d   = StWait;
                    lat_cnt_d = lat_cnt_t'(RD_LAT - 1);
                end
            end
            StWait: begin
                if (flush_i) begin
                    state_d = StIdle;
                    drop_d  = 1'b1;
                end else if (lat_cnt_q == '0) begin
                    // Last wait cycle: FIFO data is valid now.
                    state_d = StDeliver;
                    dat_d   = fifo_dout_i;
                    vld0_d  = ~gnt_q;
                    vld1_d  = gnt_q;
                end else begin
                    lat_cnt_d = lat_cnt_q - lat_cnt_t'(1);
                end
            end
            StDeliver: begin
                state_d = StIdle;
                drop_d  = drop_q | flush_i;
                start   = gnt_vld;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d   = StPop;
            last_d    = gnt_id;
            gnt_d     = gnt_id;
            pop_d     = 1'b1;
            pop_cnt_d = pop_cnt_q + 16'd1;
        end
    end

    assign busy_d = (state_d != StIdle);

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            pop_q     <= 1'b0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            pop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            pop_q     <= pop_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    assign fifo_pop_o = pop_q;
    assign vld0_o     = vld0_q;
    assign vld1_o     = vld1_q;
    assign dat_o      = dat_q;
    assign gnt_id_o   = gnt_q;
    assign busy_o     = busy_q;
    assign dropped_o  = drop_q;
    assign pop_cnt_o  = pop_cnt_q;

endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// Bench for fifo_pop_scheduler: FIFO stand-in with read latency, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_fifo_pop_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;
    localparam int unsigned FW = 4;

    logic          WBs_CLK_i       = 1'b0;
    logic          WBs_RSTn_i      = 1'b0;
    logic          req0_i          = 1'b0;
    logic          req1_i          = 1'b0;
    logic          flush_i         = 1'b0;
    logic [FW-1:0] fifo_pop_flag_i = '0;
    logic [DW-1:0] fifo_dout_i     = '0;
    logic          fifo_pop_o;
    logic          vld0_o;
    logic          vld1_o;
    logic [DW-1:0] dat_o;
    logic          gnt_id_o;
    logic          busy_o;
    logic          dropped_o;
    logic [15:0]   pop_cnt_o;

    fifo_pop_scheduler #(
        .DATAWIDTH (DW),
        .RD_LAT    (RL),
        .FLAGWIDTH (FW)
    ) dut (
        .WBs_CLK_i       (WBs_CLK_i),
        .WBs_RSTn_i      (WBs_RSTn_i),
        .req0_i          (req0_i),
        .req1_i          (req1_i),
        .flush_i         (flush_i),
        .fifo_pop_flag_i (fifo_pop_flag_i),
        .fifo_dout_i     (fifo_dout_i),
        .fifo_pop_o      (fifo_pop_o),
        .vld0_o          (vld0_o),
        .vld1_o          (vld1_o),
        .dat_o           (dat_o),
        .gnt_id_o        (gnt_id_o),
        .busy_o          (busy_o),
        .dropped_o       (dropped_o),
        .pop_cnt_o       (pop_cnt_o)
    );

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // FIFO stand-in: queue of stored words plus a read-latency delay line.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] pipe_dat[RL];
    bit            pipe_vld[RL];
    bit            prev_pop = 1'b0;

    // Observed events for directed checks.
    int            pop_cyc[$];
    int            pop_gnt[$];
    int            del0_cyc[$];
    int            del1_cyc[$];
    logic [DW-1:0] del0_dat[$];
    logic [DW-1:0] del1_dat[$];

    // Reference model: a transaction is "active" for RL+2 cycles counted by age
    // (0 = pop cycle, RL+1 = delivery cycle).
    bit            m_active;
    int            m_age;
    bit            m_last;
    bit            m_gnt;
    bit            m_drop;
    logic [15:0]   m_cnt;
    logic [DW-1:0] m_dat;
    logic [DW-1:0] m_word;
    bit            m_pop;
    bit            m_v0;
    bit            m_v1;

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_last   = 1'b1;
        m_gnt    = 1'b0;
        m_drop   = 1'b0;
        m_cnt    = '0;
        m_dat    = '0;
        m_word   = '0;
        m_pop    = 1'b0;
        m_v0     = 1'b0;
        m_v1     = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit can_arb;
        bit id;
        m_pop = 1'b0;
        m_v0  = 1'b0;
        m_v1  = 1'b0;
        if (m_active) begin
            if (flush_i) begin
                m_active = 1'b0;
                m_drop   = 1'b1;
                can_arb  = 1'b0;
            end else if (m_age == int'(RL) + 1) begin
                m_active = 1'b0;
                can_arb  = 1'b1;
            end else begin
                m_age++;
                can_arb = 1'b0;
                if (m_age == int'(RL) + 1) begin
                    m_dat = m_word;
                    m_v0  = (m_gnt == 1'b0);
                    m_v1  = (m_gnt == 1'b1);
                end
            end
        end else begin
            can_arb = !flush_i;
        end
        if (can_arb && fifo_pop_flag_i != '0 && (req0_i || req1_i)) begin
            id       = (req0_i && req1_i) ? !m_last : req1_i;
            m_last   = id;
            m_gnt    = id;
            m_active = 1'b1;
            m_age    = 0;
            m_pop    = 1'b1;
            m_cnt    = m_cnt + 16'd1;
            m_word   = (fq.size() != 0) ? fq[0] : '0;
        end
    endtask

    // Monitor: FIFO stand-in, model update and per-cycle comparison.
    always @(posedge WBs_CLK_i) begin
        #1;
        cyc++;
        if (!WBs_RSTn_i) begin
            model_reset();
            fq.delete();
            for (int i = 0; i < int'(RL); i++) begin
                pipe_vld[i] = 1'b0;
                pipe_dat[i] = '0;
            end
        end else begin
            for (int i = int'(RL) - 1; i > 0; i--) begin
                pipe_dat[i] = pipe_dat[i-1];
                pipe_vld[i] = pipe_vld[i-1];
            end
            pipe_vld[0] = 1'b0;
            if (prev_pop && fq.size() != 0) begin
                pipe_dat[0] = fq.pop_front();
                pipe_vld[0] = 1'b1;
            end
            model_step();
            chk_b("fifo_pop", fifo_pop_o, m_pop);
            chk_b("vld0", vld0_o, m_v0);
            chk_b("vld1", vld1_o, m_v1);
            chk_b("busy", busy_o, m_active);
            chk_b("gnt_id", gnt_id_o, m_gnt);
            chk_b("dropped", dropped_o, m_drop);
            chk_w("pop_cnt", 32'(pop_cnt_o), 32'(m_cnt));
            chk_w("dat", dat_o, m_dat);
            if (fifo_pop_o) begin
                pop_cyc.push_back(cyc);
                pop_gnt.push_back(int'(gnt_id_o));
            end
            if (vld0_o) begin
                del0_cyc.push_back(cyc);
                del0_dat.push_back(dat_o);
            end
            if (vld1_o) begin
                del1_cyc.push_back(cyc);
                del1_dat.push_back(dat_o);
            end
        end
        prev_pop = WBs_RSTn_i ? fifo_pop_o : 1'b0;
    end

    task automatic drive(input bit r0, input bit r1, input bit fl);
        @(negedge WBs_CLK_i);
        req0_i  = r0;
        req1_i  = r1;
        flush_i = fl;
        if (fq.size() == 0) begin
            fifo_pop_flag_i = '0;
        end else if (fq.size() > 15) begin
            fifo_pop_flag_i = '1;
        end else begin
            fifo_pop_flag_i = FW'(fq.size());
        end
        fifo_dout_i = pipe_vld[RL-1] ? pipe_dat[RL-1] : DW'($urandom());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_obs();
        pop_cyc.delete();
        pop_gnt.delete();
        del0_cyc.delete();
        del1_cyc.delete();
        del0_dat.delete();
        del1_dat.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_b({tag, "_pop"}, fifo_pop_o, 1'b0);
        chk_b({tag, "_vld0"}, vld0_o, 1'b0);
        chk_b({tag, "_vld1"}, vld1_o, 1'b0);
        chk_w({tag, "_dat"}, dat_o, 32'h0);
        chk_b({tag, "_gnt"}, gnt_id_o, 1'b0);
        chk_b({tag, "_busy"}, busy_o, 1'b0);
        chk_b({tag, "_dropped"}, dropped_o, 1'b0);
        chk_w({tag, "_pop_cnt"}, 32'(pop_cnt_o), 32'h0);
    endtask

    task automatic reset_pulse();
        @(negedge WBs_CLK_i);
        WBs_RSTn_i = 1'b0;
        idle(2);
        WBs_RSTn_i = 1'b1;
    endtask

    initial begin
        int c0;
        model_reset();
        for (int i = 0; i < int'(RL); i++) begin
            pipe_vld[i] = 1'b0;
            pipe_dat[i] = '0;
        end

        // Power-on reset.
        idle(3);
        chk_all_zero("por");
        WBs_RSTn_i = 1'b1;

        // Round-robin: both requests held, words 1..4; first tie goes to requester 0.
        for (int i = 1; i <= 4; i++) fq.push_back(DW'(i));
        clear_obs();
        drive(1'b1, 1'b1, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0);
        idle(2);
        chk_w("rr_pop_count", 32'(pop_cyc.size()), 32'd4);
        if (pop_cyc.size() == 4) begin
            chk_w("rr_first_pop", 32'(pop_cyc[0]), 32'(c0 + 1));
            for (int i = 1; i < 4; i++) begin
                chk_w("rr_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd4);
                chk_w("rr_gnt", 32'(pop_gnt[i]), 32'(i % 2));
            end
            chk_w("rr_gnt0", 32'(pop_gnt[0]), 32'd0);
        end
        chk_w("rr_del0_count", 32'(del0_dat.size()), 32'd2);
        chk_w("rr_del1_count", 32'(del1_dat.size()), 32'd2);
        if (del0_dat.size() == 2 && del1_dat.size() == 2) begin
            chk_w("rr_del0_a", del0_dat[0], 32'd1);
            chk_w("rr_del0_b", del0_dat[1], 32'd3);
            chk_w("rr_del1_a", del1_dat[0], 32'd2);
            chk_w("rr_del1_b", del1_dat[1], 32'd4);
            chk_w("rr_del0_cyc", 32'(del0_cyc[0]), 32'(c0 + 4));
        end

        // Asynchronous reset in the middle of a transaction.
        fq.push_back(32'hDEAD0001);
        drive(1'b0, 1'b1, 1'b0);
        idle(2);
        #2 WBs_RSTn_i = 1'b0;
        #1 chk_all_zero("async_rst");
        idle(2);
        WBs_RSTn_i = 1'b1;

        // First tie after that reset goes to requester 0.
        fq.push_back(32'h11110000);
        fq.push_back(32'h22220000);
        clear_obs();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
        idle(2);
        chk_w("tie_after_rst_pops", 32'(pop_gnt.size()), 32'd2);
        if (pop_gnt.size() == 2) chk_w("tie_after_rst_gnt", 32'(pop_gnt[0]), 32'd0);
        if (del0_dat.size() != 0) chk_w("tie_after_rst_dat", del0_dat[0], 32'h11110000);

        // Single read after a clean reset.
        reset_pulse();
        fq.push_back(32'hA5A50001);
        clear_obs();
        drive(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0);
        chk_w("single_pops", 32'(pop_cyc.size()), 32'd1);
        if (pop_cyc.size() == 1) chk_w("single_pop_cyc", 32'(pop_cyc[0]), 32'(c0 + 1));
        chk_w("single_del0", 32'(del0_dat.size()), 32'd1);
        if (del0_dat.size() == 1) begin
            chk_w("single_dat", del0_dat[0], 32'hA5A50001);
            chk_w("single_vld_cyc", 32'(del0_cyc[0]), 32'(c0 + 4));
        end
        chk_w("single_del1", 32'(del1_dat.size()), 32'd0);
        chk_w("single_pop_cnt", 32'(pop_cnt_o), 32'd1);

        // Both requests with empty FIFO: no pop, last grant (0) unchanged.
        clear_obs();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
        chk_w("empty_both_pops", 32'(pop_cyc.size()), 32'd0);
        fq.push_back(32'h0BAD0BAD);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
        chk_w("empty_both_later", 32'(pop_gnt.size()), 32'd1);
        if (pop_gnt.size() == 1) chk_w("empty_both_gnt", 32'(pop_gnt[0]), 32'd1);
        idle(3);

        // Empty gating: req1 held 20 cycles on empty FIFO, data appears at cycle 20.
        clear_obs();
        drive(1'b0, 1'b1, 1'b0);
        c0 = cyc;
        for (int i = 1; i < 20; i++) drive(1'b0, 1'b1, 1'b0);
        chk_w("gate_no_pop", 32'(pop_cyc.size()), 32'd0);
        fq.push_back(32'h00C0FFEE);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk_w("gate_pops", 32'(pop_cyc.size()), 32'd1);
        if (pop_cyc.size() == 1) chk_w("gate_pop_cyc", 32'(pop_cyc[0]), 32'(c0 + 21));
        idle(6);

        // Flush in the second wait cycle.
        chk_b("pre_flush_dropped", dropped_o, 1'b0);
        fq.push_back(32'hF1F1F1F1);
        clear_obs();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk_b("flush_busy", busy_o, 1'b0);
        chk_b("flush_dropped", dropped_o, 1'b1);
        idle(4);
        chk_w("flush_no_vld", 32'(del0_dat.size() + del1_dat.size()), 32'd0);

        // Request dropped right after grant still gets its strobe.
        fq.push_back(32'h5A5A0002);
        clear_obs();
        drive(1'b0, 1'b1, 1'b0);
        c0 = cyc;
        idle(6);
        chk_w("committed_del1", 32'(del1_dat.size()), 32'd1);
        if (del1_dat.size() == 1) begin
            chk_w("committed_dat", del1_dat[0], 32'h5A5A0002);
            chk_w("committed_cyc", 32'(del1_cyc[0]), 32'(c0 + 4));
        end

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if (fq.size() < 5 && $urandom_range(0, 3) == 0) fq.push_back(DW'($urandom()));
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0));
        end
        idle(8);

        // Counter wrap: preload the count to 0xFFFF, then one more pop.
        @(negedge WBs_CLK_i);
        force dut.pop_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        drive(1'b0, 1'b0, 1'b0);
        release dut.pop_cnt_q;
        idle(1);
        chk_w("wrap_preload", 32'(pop_cnt_o), 32'h0000FFFF);
        fq.push_back(32'h77777777);
        drive(1'b1, 1'b0, 1'b0);
        idle(6);
        chk_w("wrap_pop_cnt", 32'(pop_cnt_o), 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
